usr_deser: RTL

Serial-to-parallel frame receiver that pairs with the universal shift register. It recovers WIDTH-bit words from a framed serial stream, such as the stream produced when the shift register shifts a parallel word out through its serial port. It checks framing and even parity, then presents each word on a valid/ready output with a one-entry holding register. It sits between the serial link and the parallel consumer logic.

---
 rtl/usr_pkg.sv | 15 +
 rtl/usr_rx_shifter.sv | 30 +++
 rtl/usr_deser.sv | 116 +++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/usr_rx_shifter.sv
// Serial-in shift register with selectable direction and a running XOR of shifted-in bits.
module usr_rx_shifter #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             x
);

  // clr restarts the XOR for a new frame; en shifts one bit in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
      x <= 1'b0;
    end else if (clr) begin
      q <= '0;
      x <= 1'b0;
    end else if (en) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], din};
      else           q <= {din, q[WIDTH-1:1]};
      x <= x ^ din;
    end
  end

endmodule

// File: rtl/usr_deser.sv
// Framed serial receiver: start, WIDTH data bits, optional even parity, stop;
// good words go to a one-entry valid/ready holding register.
module usr_deser
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             par_err,
  output logic             frm_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             dx;
  logic             pe;

  logic start_hit;
  logic shift_hit;
  logic last_bit;
  logic stop_hit;
  logic good_hit;
  logic load_hit;

  assign start_hit = sin_en && (state == IDLE) && (sin == START_BIT);
  assign shift_hit = sin_en && (state == DATA);
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign stop_hit  = sin_en && (state == STOP);
  assign good_hit  = stop_hit && (sin == STOP_BIT);
  assign load_hit  = good_hit && (!dout_valid || dout_ready);

  usr_rx_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .clr   (start_hit),
    .en    (shift_hit),
    .din   (sin),
    .q     (word),
    .x     (dx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Transitions only advance on strobe cycles.
  always_comb begin
    state_nx = state;
    if (sin_en) begin
      case (state)
        IDLE:    if (sin == START_BIT) state_nx = DATA;
        DATA:    if (last_bit) state_nx = PARITY_EN ? PARITY : STOP;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cnt <= '0;
    else if (start_hit) cnt <= '0;
    else if (shift_hit) cnt <= last_bit ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pe <= 1'b0;
    else if (start_hit)
      pe <= 1'b0;
    else if (PARITY_EN && sin_en && (state == PARITY))
      pe <= sin ^ dx;
  end

  // Holding register and status flags; a load wins over a same-cycle drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frm_err <= stop_hit && (sin != STOP_BIT);
      overrun <= good_hit && !load_hit;
      busy    <= (state_nx != IDLE);
      if (load_hit) begin
        dout       <= word;
        par_err    <= pe;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
